// File: rtl/vcve2_vrf_mem_responder_if.sv
// Bundled req/gnt/rvalid data-memory port for NumIfs initiators sharing one responder.
interface vcve2_vrf_mem_responder_if #(
    parameter int unsigned NumIfs = 1
);
    logic [NumIfs-1:0]       req;
    logic [NumIfs-1:0]       gnt;
    logic [NumIfs-1:0][31:0] addr;
    logic [NumIfs-1:0]       we;
    logic [NumIfs-1:0][3:0]  be;
    logic [NumIfs-1:0][31:0] wdata;
    logic [NumIfs-1:0]       rvalid;
    logic [NumIfs-1:0]       err;
    logic [NumIfs-1:0][31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/vcve2_vrf_mem_responder.sv
// Shared word-addressed bank serving NumIfs req/gnt/rvalid ports with round-robin arbitration,
// optional grant delay and a fixed-latency response pipeline.
module vcve2_vrf_mem_responder #(
    parameter int unsigned NumIfs      = 1,
    parameter int unsigned Depth       = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0000_0000,
    parameter int unsigned RespLatency = 1,
    parameter int unsigned GntDelay    = 0
) (
    input logic                             clk_i,
    input logic                             rst_ni,
    vcve2_vrf_mem_responder_if.slave        data_io
);
    localparam int unsigned PtrW = (NumIfs > 1) ? $clog2(NumIfs) : 1;
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [0:0] {StArb, StWait} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] win_q, win_d;
    logic [2:0]      cnt_q, cnt_d;

    logic            arb_found;
    logic [PtrW-1:0] arb_win;
    logic            gnt_vld;
    logic [PtrW-1:0] gnt_port;

    logic [31:0]     sel_addr;
    logic [31:0]     sel_off;
    logic            sel_err;
    logic [IdxW-1:0] sel_idx;
    logic [31:0]     rdata_new;

    logic [31:0]     mem_q [Depth];

    logic [RespLatency-1:0] pv_q;
    logic [PtrW-1:0]        pport_q  [RespLatency];
    logic                   perr_q   [RespLatency];
    logic [31:0]            prdata_q [RespLatency];

    // First requester at or after ptr, wrapping modulo NumIfs.
    always_comb begin
        logic [PtrW-1:0] cand;
        arb_found = 1'b0;
        arb_win   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NumIfs; k++) begin
            cand = PtrW'((32'(ptr_q) + k) % NumIfs);
            if (!arb_found && data_io.req[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_vld  = 1'b0;
        gnt_port = win_q;
        unique case (state_q)
            StArb: begin
                // Grants are suppressed while reset is held so every output stays 0.
                if (arb_found && rst_ni) begin
                    if (GntDelay == 0) begin
                        gnt_vld  = 1'b1;
                        gnt_port = arb_win;
                    end else begin
                        win_d   = arb_win;
                        cnt_d   = 3'(GntDelay);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!data_io.req[win_q]) begin
                    state_d = StArb;
                end else if (cnt_q == 3'd1) begin
                    gnt_vld  = 1'b1;
                    gnt_port = win_q;
                    state_d  = StArb;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StArb;
        endcase
        if (gnt_vld) begin
            ptr_d = (gnt_port == PtrW'(NumIfs - 1)) ? '0 : gnt_port + PtrW'(1);
        end
    end

    assign sel_addr  = data_io.addr[gnt_port];
    assign sel_off   = sel_addr - BaseAddr;
    assign sel_err   = (sel_addr < BaseAddr) || ({32'd0, sel_off} >= (64'(Depth) << 2)) ||
                       (sel_addr[1:0] != 2'b00);
    assign sel_idx   = sel_off[IdxW+1:2];
    assign rdata_new = (gnt_vld && !sel_err && !data_io.we[gnt_port]) ? mem_q[sel_idx] : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StArb;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bank contents survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt_vld && !sel_err && data_io.we[gnt_port]) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_io.be[gnt_port][b]) begin
                    mem_q[sel_idx][8*b +: 8] <= data_io.wdata[gnt_port][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pport_q[i]  <= '0;
                perr_q[i]   <= 1'b0;
                prdata_q[i] <= '0;
            end
        end else begin
            pv_q[0]     <= gnt_vld;
            pport_q[0]  <= gnt_port;
            perr_q[0]   <= gnt_vld & sel_err;
            prdata_q[0] <= rdata_new;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pv_q[i]     <= pv_q[i-1];
                pport_q[i]  <= pport_q[i-1];
                perr_q[i]   <= perr_q[i-1];
                prdata_q[i] <= prdata_q[i-1];
            end
        end
    end

    always_comb begin
        data_io.gnt    = '0;
        data_io.rvalid = '0;
        data_io.err    = '0;
        data_io.rdata  = '0;
        if (gnt_vld) begin
            data_io.gnt[gnt_port] = 1'b1;
        end
        if (pv_q[RespLatency-1]) begin
            data_io.rvalid[pport_q[RespLatency-1]] = 1'b1;
            data_io.err[pport_q[RespLatency-1]]    = perr_q[RespLatency-1];
            data_io.rdata[pport_q[RespLatency-1]]  = prdata_q[RespLatency-1];
        end
    end
endmodule

// File: doc/vcve2_vrf_mem_responder.md
Name: vcve2_vrf_mem_responder

Overview:
- Memory-side responder for the vector unit's per-interface data memory ports (req/gnt/rvalid protocol).
- Serves NumIfs initiator ports from one shared word-addressed bank. Arbitration is round-robin; grant timing and response latency are parameterisable.
- Used as the data memory model in block and subsystem benches. It is also the synthesizable scratch-bank behind the vector LSU.

Parameters:
- NumIfs, 1, number of initiator ports (1..3).
- Depth, 1024, bank size in 32-bit words (power of two).
- BaseAddr, 32'h0000_0000, byte address of word 0.
- RespLatency, 1, cycles from the grant cycle to rvalid (1..4).
- GntDelay, 0, extra cycles a winning request is held before gnt (0..7).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  [NumIfs-1:0]  request per port.
- data_gnt_o  out  [NumIfs-1:0]  grant per port.
- data_addr_i  in  [NumIfs-1:0][31:0]  byte address.
- data_we_i  in  [NumIfs-1:0]  1 = write.
- data_be_i  in  [NumIfs-1:0][3:0]  byte enables.
- data_wdata_i  in  [NumIfs-1:0][31:0]  write data.
- data_rvalid_o  out  [NumIfs-1:0]  response valid, one-cycle pulse.
- data_err_o  out  [NumIfs-1:0]  response error, qualified by rvalid.
- data_rdata_o  out  [NumIfs-1:0][31:0]  read data, qualified by rvalid.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - All outputs 0.
  - FSM goes to ARB; round-robin pointer = 0; wait counter = 0.
  - Response pipeline is flushed. Responses pending at reset are dropped and never issued.
  - Bank contents are not reset.
- Address decode:
  - off = addr - BaseAddr; index = off[31:2].
  - err = (addr < BaseAddr) | (index >= Depth) | (addr[1:0] != 0).
  - An err access is granted normally but does not touch the bank.
- Arbitration, state ARB:
  - Among ports with req high, pick the first at or after ptr, wrapping modulo NumIfs.
  - If GntDelay = 0: gnt[winner] = 1 combinationally in the same cycle; ptr <= winner+1 (mod NumIfs).
  - If GntDelay > 0: latch the winner, load counter = GntDelay, go to WAIT; no gnt this cycle.
  - At most one gnt bit high per cycle.
- State WAIT:
  - Only the latched winner is considered. The counter decrements each cycle.
  - When counter = 1 and req[winner] is high: assert gnt[winner] that cycle, update ptr, return to ARB.
  - If req[winner] drops in WAIT (protocol violation): return to ARB with no gnt and no access.
  - Initiators hold addr/we/be/wdata stable from req until gnt.
- Access, performed at the clock edge ending the grant cycle:
  - Write: bytes with be=1 are updated; other bytes unchanged; be=0 is a legal no-op.
  - Read: samples the word as stored before that edge.
  - A write granted in cycle N is visible to a read granted in N+1.
- Response:
  - A shift pipeline of depth RespLatency carries {valid, port, err, rdata}.
  - Exactly RespLatency cycles after the grant cycle, rvalid[port] = 1 for one cycle.
  - Read: rdata = sampled word. Write or err: rdata = 0. err as decoded.
  - Throughput is one grant per cycle (GntDelay = 0); responses return in grant order.
  - No backpressure on responses.
- Boundaries:
  - Last word (index Depth-1) is valid; index Depth gives err.
  - ptr wraps NumIfs-1 -> 0.
  - A port may re-request in the cycle after its gnt.
  - A grant and a response for the same port may coincide in one cycle.

Test Plan:
- NumIfs=1, RespLatency=1: write 0xDEADBEEF to 0x10 be=4'hF, then read 0x10 next cycle -> gnt same cycle; rvalid one cycle later; read rdata=0xDEADBEEF; write response rdata=0, err=0.
- Byte enables: word 0x10 = 0x11223344, write be=4'b0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
- NumIfs=3, all ports request every cycle for 6 cycles -> gnt sequence port 0,1,2,0,1,2; each rvalid routed to the correct port.
- Errors, Depth=1024 BaseAddr=0: read 0x1000, read 0x3 -> each granted, rvalid with err=1 and rdata=0; read 0xFFC -> err=0.
- GntDelay=2, RespLatency=3: req at cycle 0 -> gnt at cycle 2, rvalid at cycle 5. Second run with req dropped at cycle 1 -> no gnt and no rvalid.
- Reset mid-operation: assert rst_ni low one cycle after a read grant with RespLatency=3 -> no rvalid after reset; written bank data retained.
